// File: rtl/status_reporter_pkg.sv
// Shared constants and state type for the status line transmitter.
package status_reporter_pkg;

    localparam logic [3:0] MSG_LEN  = 4'd14;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_QUERY = 8'h3F;
    localparam logic [7:0] CH_M     = 8'h4D;
    localparam logic [7:0] CH_F     = 8'h46;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

endpackage

// File: rtl/status_reporter_if.sv
// Serial byte stream bundle: received bytes in, transmitter byte handshake out.
interface status_reporter_if;

    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;

    modport master (
        output rx_data,
        output new_rx_data,
        output tx_busy,
        input  tx_data,
        input  new_tx_data
    );

    modport slave (
        input  rx_data,
        input  new_rx_data,
        input  tx_busy,
        output tx_data,
        output new_tx_data
    );

endinterface

// File: rtl/status_reporter_nibble_to_ascii.sv
// Combinational conversion of one nibble to its uppercase ASCII hex digit.
module nibble_to_ascii
    import status_reporter_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    // 'A' - 10 = 8'h37, so letters share one adder with the digits.
    assign o_ascii = (i_nibble < 4'd10) ? (CH_ZERO + {4'h0, i_nibble})
                                        : (8'h37   + {4'h0, i_nibble});

endmodule

// File: rtl/status_reporter.sv
// Sends "M<mode> F<8 hex>\r\n" on a '?' request; STATUS_AUTO_REPORT_EN also reports on any change.
module status_reporter
    import status_reporter_pkg::*;
#(
    parameter int FREQ_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FREQ_W-1:0] i_freq,
    input  logic [1:0]        i_mode,
    status_reporter_if.slave  io_ser,
    output logic              o_busy
);

    state_t            r_state;
    state_t            w_stateNext;
    logic [3:0]        r_index;
    logic [3:0]        w_indexNext;
    logic              r_pending;
    logic              w_pendingNext;
    logic [FREQ_W-1:0] r_snapFreq;
    logic [1:0]        r_snapMode;
    logic              w_load;
    logic              w_issue;
    logic              w_query;
    logic              w_trigger;
    logic [3:0]        w_nibble;
    logic [7:0]        w_hexChar;
    logic [7:0]        w_byte;

    assign w_query = io_ser.new_rx_data && (io_ser.rx_data == CH_QUERY);

`ifdef STATUS_AUTO_REPORT_EN
    logic [FREQ_W-1:0] r_lastFreq;
    logic [1:0]        r_lastMode;

    // Remembers what the host last saw so a drift in either input requests a new line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lastFreq <= '0;
            r_lastMode <= 2'd0;
        end else if (w_load) begin
            r_lastFreq <= i_freq;
            r_lastMode <= i_mode;
        end
    end

    assign w_trigger = w_query || (i_freq != r_lastFreq) || (i_mode != r_lastMode);
`else
    assign w_trigger = w_query;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_index    <= 4'd0;
            r_pending  <= 1'b0;
            r_snapFreq <= '0;
            r_snapMode <= 2'd0;
        end else begin
            r_state   <= w_stateNext;
            r_index   <= w_indexNext;
            r_pending <= w_pendingNext;
            if (w_load) begin
                r_snapFreq <= i_freq;
                r_snapMode <= i_mode;
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_indexNext   = r_index;
        w_pendingNext = r_pending;
        w_load        = 1'b0;
        w_issue       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_load      = 1'b1;
                    w_indexNext = 4'd0;
                    w_stateNext = SEND;
                end
            end
            SEND: begin
                if (w_trigger) begin
                    w_pendingNext = 1'b1;
                end
                if (!io_ser.tx_busy) begin
                    w_issue     = 1'b1;
                    w_indexNext = r_index + 4'd1;
                    w_stateNext = GAP;
                end
            end
            GAP: begin
                // A request landing on the final spacer is folded into the follow-up line.
                if (r_index == MSG_LEN) begin
                    if (r_pending || w_trigger) begin
                        w_load        = 1'b1;
                        w_pendingNext = 1'b0;
                        w_indexNext   = 4'd0;
                        w_stateNext   = SEND;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end else begin
                    if (w_trigger) begin
                        w_pendingNext = 1'b1;
                    end
                    w_stateNext = SEND;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Byte positions 4..11 carry the tuning word, most significant nibble first.
    always_comb begin
        w_nibble = 4'h0;
        case (r_index)
            4'd4:    w_nibble = r_snapFreq[31:28];
            4'd5:    w_nibble = r_snapFreq[27:24];
            4'd6:    w_nibble = r_snapFreq[23:20];
            4'd7:    w_nibble = r_snapFreq[19:16];
            4'd8:    w_nibble = r_snapFreq[15:12];
            4'd9:    w_nibble = r_snapFreq[11:8];
            4'd10:   w_nibble = r_snapFreq[7:4];
            4'd11:   w_nibble = r_snapFreq[3:0];
            default: w_nibble = 4'h0;
        endcase
    end

    nibble_to_ascii u_hex (
        .i_nibble (w_nibble),
        .o_ascii  (w_hexChar)
    );

    always_comb begin
        w_byte = 8'h00;
        case (r_index)
            4'd0:    w_byte = CH_M;
            4'd1:    w_byte = CH_ZERO | {6'b000000, r_snapMode};
            4'd2:    w_byte = CH_SPACE;
            4'd3:    w_byte = CH_F;
            4'd4, 4'd5, 4'd6, 4'd7,
            4'd8, 4'd9, 4'd10, 4'd11:
                     w_byte = w_hexChar;
            4'd12:   w_byte = CH_CR;
            4'd13:   w_byte = CH_LF;
            default: w_byte = 8'h00;
        endcase
    end

    assign io_ser.new_tx_data = w_issue;
    assign io_ser.tx_data     = w_issue ? w_byte : 8'h00;
    assign o_busy             = (r_state != IDLE);

endmodule

// File: tb/tb_status_reporter.sv
// Randomized scoreboard bench for status_reporter; honours STATUS_AUTO_REPORT_EN when defined.
module tb_status_reporter;

    localparam int LINE_LEN = 14;

    logic        clk     = 1'b0;
    logic        rstN    = 1'b0;
    logic [31:0] freq    = 32'h0;
    logic [1:0]  mode    = 2'd0;
    logic        busyOut;

    status_reporter_if serIf ();

    status_reporter #(.FREQ_W(32)) dut (
        .clk    (clk),
        .rst_n  (rstN),
        .i_freq (freq),
        .i_mode (mode),
        .io_ser (serIf.slave),
        .o_busy (busyOut)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a line is a list of bytes plus timestamps of when the next byte may go.
    logic [7:0] expQ[$];
    int         cycle        = 0;
    bit         mActive      = 1'b0;
    int         mSent        = 0;
    int         mNextAllowed = 0;
    bit         mPending     = 1'b0;
    bit         mIssueNow    = 1'b0;
    bit         mTrig;
`ifdef STATUS_AUTO_REPORT_EN
    logic [31:0] mLastFreq = 32'h0;
    logic [1:0]  mLastMode = 2'd0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic startLine();
        logic [3:0] nib;
        expQ.push_back(8'h4D);
        expQ.push_back(8'h30 + {6'd0, mode});
        expQ.push_back(8'h20);
        expQ.push_back(8'h46);
        for (int k = 7; k >= 0; k--) begin
            nib = freq[k*4 +: 4];
            expQ.push_back((nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h41 + {4'h0, nib} - 8'd10));
        end
        expQ.push_back(8'h0D);
        expQ.push_back(8'h0A);
        mActive      = 1'b1;
        mSent        = 0;
        mNextAllowed = cycle + 1;
        mPending     = 1'b0;
`ifdef STATUS_AUTO_REPORT_EN
        mLastFreq = freq;
        mLastMode = mode;
`endif
    endtask

    always @(posedge clk) begin
        mTrig = serIf.new_rx_data && (serIf.rx_data == 8'h3F);
`ifdef STATUS_AUTO_REPORT_EN
        mTrig = mTrig || (freq != mLastFreq) || (mode != mLastMode);
`endif
        if (!rstN) begin
            mActive   = 1'b0;
            mSent     = 0;
            mPending  = 1'b0;
            mIssueNow = 1'b0;
            expQ.delete();
`ifdef STATUS_AUTO_REPORT_EN
            mLastFreq = 32'h0;
            mLastMode = 2'd0;
`endif
        end else begin
            if (mIssueNow) begin
                mSent++;
                mNextAllowed = cycle + 2;
            end
            if (!mActive) begin
                if (mTrig) startLine();
            end else if (mSent == LINE_LEN && cycle + 1 >= mNextAllowed) begin
                if (mPending || mTrig) startLine();
                else mActive = 1'b0;
            end else if (mTrig) begin
                mPending = 1'b1;
            end
        end
        cycle++;
    end

    // Cycle-level timing check of the handshake against the model.
    always @(negedge clk) begin
        mIssueNow = mActive && (mSent < LINE_LEN) && (cycle >= mNextAllowed) && !serIf.tx_busy;
        checkOutput("new_tx_data", {31'd0, serIf.new_tx_data}, {31'd0, mIssueNow});
        checkOutput("busy", {31'd0, busyOut}, {31'd0, mActive});
        if (!mIssueNow) checkOutput("tx_data idle", {24'd0, serIf.tx_data}, 32'h0);
    end

    // Monitor: every byte the DUT issues is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (serIf.new_tx_data) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected byte: got %0h, expected none (cycle %0d)", serIf.tx_data, cycle);
            end else begin
                checkOutput("tx byte", {24'd0, serIf.tx_data}, {24'd0, expQ.pop_front()});
            end
        end
    end

    task automatic applyStimulus(input bit strobe, input logic [7:0] data);
        serIf.new_rx_data = strobe;
        serIf.rx_data     = data;
        @(posedge clk);
        #1;
        serIf.new_rx_data = 1'b0;
        serIf.rx_data     = 8'h00;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget && (mActive || expQ.size() != 0); i++) applyStimulus(1'b0, 8'h00);
        if (mActive || expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL line drain timeout: got active, expected idle within %0d cycles", budget);
        end
    endtask

    task automatic waitSent(input int n, input int budget);
        for (int i = 0; i < budget && mSent < n; i++) applyStimulus(1'b0, 8'h00);
        if (mSent < n) begin
            total++;
            bad++;
            $display("[TB] FAIL byte wait timeout: got %0d bytes, expected %0d", mSent, n);
        end
    endtask

    int         r;
    logic [7:0] rb;

    initial begin
        serIf.rx_data     = 8'h00;
        serIf.new_rx_data = 1'b0;
        serIf.tx_busy     = 1'b0;
        @(posedge clk);
        #1;
        idleCycles(3);
        freq = 32'h0020C49B;
        mode = 2'd1;
        rstN = 1'b1;
        idleCycles(2);
        waitIdle(100);

        $display("[TB] basic line");
        applyStimulus(1'b1, 8'h3F);
        waitIdle(100);

        $display("[TB] tx_busy stall on byte 5");
        applyStimulus(1'b1, 8'h3F);
        waitSent(5, 100);
        serIf.tx_busy = 1'b1;
        idleCycles(50);
        serIf.tx_busy = 1'b0;
        waitIdle(100);

        $display("[TB] freq change mid-line");
        applyStimulus(1'b1, 8'h3F);
        idleCycles(6);
        freq = 32'hFFFFFFFF;
        waitIdle(100);
        applyStimulus(1'b1, 8'h3F);
        waitIdle(100);

        $display("[TB] coalesced requests");
        applyStimulus(1'b1, 8'h3F);
        idleCycles(3);
        applyStimulus(1'b1, 8'h3F);
        idleCycles(5);
        applyStimulus(1'b1, 8'h3F);
        idleCycles(5);
        applyStimulus(1'b1, 8'h3F);
        waitIdle(200);

        $display("[TB] reset mid-line");
        applyStimulus(1'b1, 8'h3F);
        waitSent(7, 100);
        rstN = 1'b0;
        idleCycles(1);
        rstN = 1'b1;
        idleCycles(10);
        waitIdle(100);

`ifdef STATUS_AUTO_REPORT_EN
        $display("[TB] automatic report on mode change");
        mode = 2'd0;
        waitIdle(200);
        mode = 2'd3;
        idleCycles(2);
        waitIdle(100);
        idleCycles(40);
`endif

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            serIf.tx_busy = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 49) == 0) freq = $urandom;
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 29);
            if (r == 0) begin
                applyStimulus(1'b1, 8'h3F);
            end else if (r == 1) begin
                rb = 8'($urandom_range(0, 255));
                applyStimulus(1'b1, rb);
            end else begin
                applyStimulus(1'b0, 8'h00);
            end
        end
        serIf.tx_busy = 1'b0;
        waitIdle(200);
        idleCycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
